// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and FSM encoding for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between register file and multiply/divide unit
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one shift-add (multiply) or restoring-subtract (divide) step per enable
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   mag_a_i,
    input  logic [XLEN-1:0]   mag_b_i,
    output logic [2*XLEN-1:0] next_o
);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   m_q;
    logic              is_div_q;

    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    assign hi = acc_q[2*XLEN-1:XLEN];
    assign lo = acc_q[XLEN-1:0];

    // Multiply: {hi, lo} holds partial product over the not-yet-consumed multiplier bits.
    assign sum      = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    assign mul_next = {sum, lo[XLEN-1:1]};

    // Divide: {hi, lo} holds remainder over dividend bits shifting into the quotient.
    // When ge is set the true difference is below m_q, so its low XLEN bits are exact.
    assign shifted  = {hi, lo[XLEN-1]};
    assign ge       = (shifted >= {1'b0, m_q});
    assign diff     = shifted[XLEN-1:0] - m_q;
    assign div_next = ge ? {diff, lo[XLEN-2:0], 1'b1}
                         : {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};

    assign next_o = is_div_q ? div_next : mul_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            m_q      <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            acc_q    <= is_div_i ? {{XLEN{1'b0}}, mag_a_i} : {{XLEN{1'b0}}, mag_b_i};
            m_q      <= is_div_i ? mag_b_i : mag_a_i;
            is_div_q <= is_div_i;
        end else if (en_i) begin
            acc_q    <= next_o;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with early-out special cases
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              load;
    logic              step_en;
    logic              is_div_in;
    logic              a_signed, b_signed, sa, sb;
    logic              div_zero, sgn_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   special_res, calc_res;
    logic [XLEN-1:0]   quo, rem;
    logic [2*XLEN-1:0] acc_next, prod;

    assign is_div_in = bus.funct3[2];
    assign a_signed  = bus.funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    assign b_signed  = bus.funct3 inside {F3_MULH, F3_DIV, F3_REM};
    assign sa        = a_signed & bus.op_a[XLEN-1];
    assign sb        = b_signed & bus.op_b[XLEN-1];
    assign mag_a     = sa ? -bus.op_a : bus.op_a;
    assign mag_b     = sb ? -bus.op_b : bus.op_b;

    assign div_zero  = is_div_in && (bus.op_b == '0);
    assign sgn_ovf   = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM)
                       && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    // funct3[1] separates the remainder ops from the quotient ops.
    assign special_res = div_zero ? (bus.funct3[1] ? bus.op_a : '1)
                                  : (bus.funct3[1] ? '0 : MIN_NEG);

    muldiv_iter u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .en_i     (step_en),
        .is_div_i (is_div_in),
        .mag_a_i  (mag_a),
        .mag_b_i  (mag_b),
        .next_o   (acc_next)
    );

    // Result is taken from the step's next value so the write-back lands on the final step.
    assign prod = neg_q ? -acc_next : acc_next;
    assign quo  = acc_next[XLEN-1:0];
    assign rem  = acc_next[2*XLEN-1:XLEN];

    always_comb begin
        calc_res = '0;
        case (f3_q)
            F3_MUL:                       calc_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              calc_res = neg_q ? -quo : quo;
            default:                      calc_res = neg_rem_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        load      = 1'b0;
        step_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d      = bus.funct3;
                    rd_d      = bus.rd_in;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    if (div_zero || sgn_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                        rd_out_d = bus.rd_in;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LAST;
                        load    = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = calc_res;
                        rd_out_d = rd_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule
